// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//
// Shared constants and helpers for the clock divider bank.
//   CLK_DIV_DIV_W         default width of a half-period value
//   CLK_DIV_NCH           default number of divider channels
//   CLK_DIV_DEFAULT_HALF  half-period loaded at reset (80 MHz / 40 = 2 MHz)
//   clamp_half()          maps a half-period of 0 to 1; other values pass
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int CLK_DIV_DIV_W        = 8;
   localparam int CLK_DIV_NCH          = 4;
   localparam int CLK_DIV_DEFAULT_HALF = 20;

   // A half-period of 0 has no meaningful period, so it is treated as the
   // fastest legal setting (1 -> clk/2). Operates on a 32-bit container so it
   // can serve any DIV_W up to 32; callers cast to their own width.
   function automatic logic [31:0] clamp_half(input logic [31:0] value);
      return (value == 32'd0) ? 32'd1 : value;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
//
// One divider channel. Produces a 50 %-duty divided clock level and
// single-cycle strobes on its rising and falling edges. The half-period can be
// changed at runtime; while running, a new value is staged and only takes
// effect at a period boundary (the high->low toggle), so no runt phases occur.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           run enable; when low the channel is parked low and loads
//                write the active half-period directly
//   sync         restart: parks the channel like en=0 for one cycle
//   half_period  new half-period value (0 is treated as 1)
//   load         write strobe for half_period
//   clk_out      divided clock level (registered)
//   rise_tick    high in the cycle clk_out becomes 1
//   fall_tick    high in the cycle clk_out becomes 0 via a count boundary
//   pend         a staged value is waiting for the next period boundary
// -----------------------------------------------------------------------------
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DIV_W        = CLK_DIV_DIV_W,
   parameter int DEFAULT_HALF = CLK_DIV_DEFAULT_HALF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic [DIV_W-1:0] half_period,
   input  logic             load,
   output logic             clk_out,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic             pend
);

   localparam logic [DIV_W-1:0] RESET_HALF = DIV_W'(DEFAULT_HALF);

   logic [DIV_W-1:0] cur_q,   cur_d;
   logic [DIV_W-1:0] nxt_q,   nxt_d;
   logic [DIV_W-1:0] count_q, count_d;
   logic             pend_q,  pend_d;
   logic             clk_out_q,   clk_out_d;
   logic             rise_tick_q, rise_tick_d;
   logic             fall_tick_q, fall_tick_d;

   logic [DIV_W-1:0] load_val;
   logic             parked;
   logic             boundary;
   logic             period_boundary;

   always_comb begin
      load_val        = DIV_W'(clamp_half(32'(half_period)));
      // sync only matters while enabled; both cases park the channel the same way
      parked          = !en || sync;
      // cur is never 0, so cur-1 cannot wrap
      boundary        = (count_q == (cur_q - DIV_W'(1)));
      // only the high->low toggle closes a full period
      period_boundary = boundary && clk_out_q;

      cur_d       = cur_q;
      nxt_d       = nxt_q;
      pend_d      = pend_q;
      count_d     = count_q;
      clk_out_d   = clk_out_q;
      rise_tick_d = 1'b0;
      fall_tick_d = 1'b0;

      if (parked) begin
         // Parked: output held low without a fall strobe; any staged value is
         // applied now, and a load in this cycle overrides it.
         count_d   = '0;
         clk_out_d = 1'b0;
         if (load) begin
            cur_d  = load_val;
            pend_d = 1'b0;
         end else if (pend_q) begin
            cur_d  = nxt_q;
            pend_d = 1'b0;
         end
      end else begin
         if (boundary) begin
            count_d     = '0;
            clk_out_d   = !clk_out_q;
            rise_tick_d = !clk_out_q;
            fall_tick_d = clk_out_q;
         end else begin
            count_d = count_q + DIV_W'(1);
         end

         // The boundary consumes the value staged before this cycle; a load in
         // the same cycle then re-stages, keeping pend set.
         if (period_boundary && pend_q) begin
            cur_d  = nxt_q;
            pend_d = 1'b0;
         end
         if (load) begin
            nxt_d  = load_val;
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q       <= RESET_HALF;
         nxt_q       <= RESET_HALF;
         pend_q      <= 1'b0;
         count_q     <= '0;
         clk_out_q   <= 1'b0;
         rise_tick_q <= 1'b0;
         fall_tick_q <= 1'b0;
      end else begin
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
         pend_q      <= pend_d;
         count_q     <= count_d;
         clk_out_q   <= clk_out_d;
         rise_tick_q <= rise_tick_d;
         fall_tick_q <= fall_tick_d;
      end
   end

   assign clk_out   = clk_out_q;
   assign rise_tick = rise_tick_q;
   assign fall_tick = fall_tick_q;
   assign pend      = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//
// Bank of NCH independent clock dividers sharing en, sync and rst. Each
// channel has its own runtime-programmable half-period; channel i uses
// half_period[i*DIV_W +: DIV_W] and load[i]. Channels with equal half-periods
// started by the same en or sync edge stay cycle-aligned.
//
// Ports:
//   clk, rst     system clock / asynchronous active-high reset
//   en           global run enable
//   sync         synchronous restart of all channels
//   half_period  packed per-channel half-period values
//   load         per-channel write strobes
//   clk_out      divided clock levels
//   rise_tick    per-channel rising-edge strobes
//   fall_tick    per-channel falling-edge strobes
//   pend         per-channel staged-value flags
// -----------------------------------------------------------------------------
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int NCH          = CLK_DIV_NCH,
   parameter int DIV_W        = CLK_DIV_DIV_W,
   parameter int DEFAULT_HALF = CLK_DIV_DEFAULT_HALF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sync,
   input  logic [NCH*DIV_W-1:0] half_period,
   input  logic [NCH-1:0]       load,
   output logic [NCH-1:0]       clk_out,
   output logic [NCH-1:0]       rise_tick,
   output logic [NCH-1:0]       fall_tick,
   output logic [NCH-1:0]       pend
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      clk_div_chan #(
         .DIV_W        (DIV_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .sync        (sync),
         .half_period (half_period[i*DIV_W +: DIV_W]),
         .load        (load[i]),
         .clk_out     (clk_out[i]),
         .rise_tick   (rise_tick[i]),
         .fall_tick   (fall_tick[i]),
         .pend        (pend[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
//
// Directed bench for clk_div_bank (NCH=4, DIV_W=8, DEFAULT_HALF=20).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "cycle n" means the state after the n-th rising edge at which
// the channel was running.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

   localparam int NCH   = 4;
   localparam int DIV_W = 8;
   localparam int DHALF = 20;

   logic                 clk;
   logic                 rst;
   logic                 en;
   logic                 sync;
   logic [NCH*DIV_W-1:0] half_period;
   logic [NCH-1:0]       load;
   logic [NCH-1:0]       clk_out;
   logic [NCH-1:0]       rise_tick;
   logic [NCH-1:0]       fall_tick;
   logic [NCH-1:0]       pend;

   int n_cmp;
   int n_err;

   clk_div_bank #(
      .NCH          (NCH),
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DHALF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .sync        (sync),
      .half_period (half_period),
      .load        (load),
      .clk_out     (clk_out),
      .rise_tick   (rise_tick),
      .fall_tick   (fall_tick),
      .pend        (pend)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic park();
      en   = 1'b0;
      load = '0;
      step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({clk_out, rise_tick, fall_tick, pend} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_async got=%h exp=0000", {clk_out, rise_tick, fall_tick, pend});
      end
      step();
      step();
      rst = 1'b0;
      step();
      n_cmp++;
      if ({clk_out, rise_tick, fall_tick, pend} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_release got=%h exp=0000", {clk_out, rise_tick, fall_tick, pend});
      end
   endtask

   task automatic test_default();
      logic [NCH-1:0] e_lvl, e_rise, e_fall;
      en = 1'b1;
      for (int n = 1; n <= 120; n++) begin
         step();
         e_lvl  = ((n / 20) % 2 == 1) ? 4'hF : 4'h0;
         e_rise = (n % 40 == 20)      ? 4'hF : 4'h0;
         e_fall = (n % 40 == 0)       ? 4'hF : 4'h0;
         n_cmp++;
         if ({clk_out, rise_tick, fall_tick, pend} !== {e_lvl, e_rise, e_fall, 4'h0}) begin
            n_err++;
            $display("FAIL default n=%0d got=%h exp=%h", n,
                     {clk_out, rise_tick, fall_tick, pend}, {e_lvl, e_rise, e_fall, 4'h0});
         end
      end
      park();
   endtask

   task automatic test_load_mid_high();
      logic [NCH-1:0] e_lvl, e_rise, e_fall, e_pend;
      en = 1'b1;
      for (int n = 1; n <= 90; n++) begin
         step();
         for (int c = 1; c < NCH; c++) begin
            e_lvl[c]  = ((n / 20) % 2 == 1);
            e_rise[c] = (n % 40 == 20);
            e_fall[c] = (n % 40 == 0);
            e_pend[c] = 1'b0;
         end
         e_lvl[0]  = (n < 20) ? 1'b0 : (n < 40) ? 1'b1 : (((n - 40) / 5) % 2 == 1);
         e_rise[0] = (n == 20) || (n >= 45 && (n - 45) % 10 == 0);
         e_fall[0] = (n >= 40 && (n - 40) % 10 == 0);
         e_pend[0] = (n >= 31 && n <= 39);
         n_cmp++;
         if ({clk_out, rise_tick, fall_tick, pend} !== {e_lvl, e_rise, e_fall, e_pend}) begin
            n_err++;
            $display("FAIL load_mid_high n=%0d got=%h exp=%h", n,
                     {clk_out, rise_tick, fall_tick, pend}, {e_lvl, e_rise, e_fall, e_pend});
         end
         if (n == 30) begin
            half_period[0 +: DIV_W] = 8'd5;
            load = 4'b0001;
         end else begin
            load = 4'b0000;
         end
      end
      park();
   endtask

   task automatic test_back_to_back();
      logic lvl, e_rise, e_fall, e_pend;
      half_period[0 +: DIV_W] = 8'd4;
      load = 4'b0001;
      step();
      load = 4'b0000;
      en   = 1'b1;
      lvl  = 1'b0;
      for (int n = 1; n <= 44; n++) begin
         step();
         e_rise = (n == 4) || (n == 11) || (n == 21) || (n == 35);
         e_fall = (n == 8) || (n == 14) || (n == 28) || (n == 42);
         e_pend = (n >= 7 && n <= 13);
         if (e_rise) lvl = 1'b1;
         if (e_fall) lvl = 1'b0;
         n_cmp++;
         if ({clk_out[0], rise_tick[0], fall_tick[0], pend[0]} !== {lvl, e_rise, e_fall, e_pend}) begin
            n_err++;
            $display("FAIL back_to_back n=%0d got=%b exp=%b", n,
                     {clk_out[0], rise_tick[0], fall_tick[0], pend[0]}, {lvl, e_rise, e_fall, e_pend});
         end
         if (n == 6) begin
            half_period[0 +: DIV_W] = 8'd3;
            load = 4'b0001;
         end else if (n == 7) begin
            half_period[0 +: DIV_W] = 8'd7;
            load = 4'b0001;
         end else begin
            load = 4'b0000;
         end
      end
      park();
   endtask

   task automatic test_sync_align();
      int h[NCH];
      logic [NCH-1:0] e_lvl, e_rise, e_fall;
      h[0] = 4; h[1] = 6; h[2] = 12; h[3] = 20;
      half_period = {8'd0, 8'd12, 8'd6, 8'd4};
      load = 4'b0111;
      step();
      load = 4'b0000;
      en   = 1'b1;
      repeat (7) step();
      // ch0 would fall on this edge and ch1 is high: sync must drop both silently
      sync = 1'b1;
      step();
      sync = 1'b0;
      n_cmp++;
      if ({clk_out, rise_tick, fall_tick} !== 12'h0) begin
         n_err++;
         $display("FAIL sync_park got=%h exp=000", {clk_out, rise_tick, fall_tick});
      end
      for (int n = 1; n <= 48; n++) begin
         step();
         for (int c = 0; c < NCH; c++) begin
            e_lvl[c]  = ((n / h[c]) % 2 == 1);
            e_rise[c] = (n % (2 * h[c]) == h[c]);
            e_fall[c] = (n % (2 * h[c]) == 0);
         end
         n_cmp++;
         if ({clk_out, rise_tick, fall_tick, pend} !== {e_lvl, e_rise, e_fall, 4'h0}) begin
            n_err++;
            $display("FAIL sync_align n=%0d got=%h exp=%h", n,
                     {clk_out, rise_tick, fall_tick, pend}, {e_lvl, e_rise, e_fall, 4'h0});
         end
      end
      park();
   endtask

   task automatic test_load_zero();
      logic e_odd;
      half_period = '0;
      load = 4'b0001;
      step();
      load = 4'b0000;
      en   = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         step();
         e_odd = (n % 2 == 1);
         n_cmp++;
         if ({clk_out[0], rise_tick[0], fall_tick[0]} !== {e_odd, e_odd, !e_odd}) begin
            n_err++;
            $display("FAIL load_zero n=%0d got=%b exp=%b", n,
                     {clk_out[0], rise_tick[0], fall_tick[0]}, {e_odd, e_odd, !e_odd});
         end
      end
      park();
   endtask

   task automatic test_reset_mid();
      logic e_lvl, e_rise, e_fall;
      en = 1'b1;
      repeat (7) step();
      n_cmp++;
      if (clk_out[1] !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_pre got=%b exp=1", clk_out[1]);
      end
      half_period[DIV_W +: DIV_W] = 8'd9;
      load = 4'b0010;
      step();
      load = 4'b0000;
      n_cmp++;
      if ({clk_out[1], pend[1]} !== 2'b11) begin
         n_err++;
         $display("FAIL rst_mid_pend got=%b exp=11", {clk_out[1], pend[1]});
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({clk_out, rise_tick, fall_tick, pend} !== 16'h0) begin
         n_err++;
         $display("FAIL rst_mid_async got=%h exp=0000", {clk_out, rise_tick, fall_tick, pend});
      end
      step();
      step();
      rst = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         step();
         e_lvl  = (n >= 20 && n < 40);
         e_rise = (n == 20);
         e_fall = (n == 40);
         n_cmp++;
         if ({clk_out, rise_tick, fall_tick, pend} !== {{NCH{e_lvl}}, {NCH{e_rise}}, {NCH{e_fall}}, 4'h0}) begin
            n_err++;
            $display("FAIL rst_mid_after n=%0d got=%h exp=%h", n,
                     {clk_out, rise_tick, fall_tick, pend},
                     {{NCH{e_lvl}}, {NCH{e_rise}}, {NCH{e_fall}}, 4'h0});
         end
      end
      park();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b0;
      en          = 1'b0;
      sync        = 1'b0;
      load        = '0;
      half_period = '0;

      test_reset();
      test_default();
      test_load_mid_high();
      test_back_to_back();
      test_sync_align();
      test_load_zero();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
